// File: rtl/serv_seqctl_pkg.sv
// Shared types and elaboration helpers for the serial-datapath sequencer.
//   state_t     : instruction phase (IDLE -> [INIT -> WAIT2] -> RUN -> IDLE)
//   chunk_last  : counter value of the final W-bit chunk of a 32-bit pass
//   w_legal     : true for supported datapath widths (1, 2, 4, 8)
package serv_seqctl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        WAIT2 = 2'd2,
        RUN   = 2'd3
    } state_t;

    function automatic logic [4:0] chunk_last(input int w);
        return 5'(32 - w);
    endfunction

    function automatic bit w_legal(input int w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8);
    endfunction

endpackage

// File: rtl/serv_seqctl_cnt.sv
// Bit-position counter for one 32-bit serial pass, W bits per cycle.
//   clk, rst  : clock, synchronous active-high reset (honoured when RESET_EN)
//   run       : a counting stage (INIT/RUN) is active
//   stall     : hold the counter and suppress all strobes
//   cnt       : LSB index of the current chunk
//   cnt_en    : counter advancing this cycle
//   cnt_done  : final chunk is being processed this cycle
module serv_seqctl_cnt
    import serv_seqctl_pkg::*;
#(
    parameter int W        = 1,
    parameter bit RESET_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       stall,
    output logic [4:0] cnt,
    output logic       cnt_en,
    output logic       cnt_done
);

    localparam logic [4:0] STEP = 5'(W);
    localparam logic [4:0] LAST = chunk_last(W);

    assign cnt_en   = run & ~stall;
    assign cnt_done = cnt_en & (cnt == LAST);

    // Outside a counting stage the counter sits at 0, so every pass starts
    // from chunk 0. The 5-bit add wraps from 32-W back to 0 by itself.
    always_ff @(posedge clk) begin
        if (rst && RESET_EN) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (!stall) begin
            cnt <= cnt + STEP;
        end
    end

endmodule

// File: rtl/serv_seqctl.sv
// State/counter controller for a W-bit-per-cycle serial RISC-V core.
// Sequences fetch, optional INIT pass, WAIT2 (memory/RF turnaround) and RUN.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_stall             : freezes counting and counter-derived strobes
//   i_* decoder inputs  : instruction class controls, compare, misalign flags
//   o_ibus_cyc/i_ibus_ack, o_dbus_cyc/i_dbus_ack : bus handshakes
//   o_rf_rreq/o_rf_wreq/i_rf_ready/o_rf_rd_en   : register-file handshakes
//   o_cnt*, o_mem_bytecnt, o_init                : pass position decodes
//   o_ctrl_pc_en/o_ctrl_jump/o_ctrl_trap         : PC control
module serv_seqctl
    import serv_seqctl_pkg::*;
#(
    parameter int    W              = 1,
    parameter string RESET_STRATEGY = "MINI",
    parameter int    WITH_CSR       = 1,
    parameter int    ALIGN          = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_stall,
    input  logic       i_new_irq,
    input  logic       i_alu_cmp,
    input  logic       i_two_stage_op,
    input  logic       i_branch_op,
    input  logic       i_cond_branch,
    input  logic       i_bne_or_bge,
    input  logic       i_shift_op,
    input  logic       i_sh_right,
    input  logic       i_slt_or_branch,
    input  logic       i_dbus_en,
    input  logic       i_e_op,
    input  logic       i_rd_op,
    input  logic       i_sh_done,
    input  logic       i_ctrl_misalign,
    input  logic       i_mem_misalign,
    output logic       o_ibus_cyc,
    input  logic       i_ibus_ack,
    output logic       o_dbus_cyc,
    input  logic       i_dbus_ack,
    output logic       o_rf_rreq,
    output logic       o_rf_wreq,
    input  logic       i_rf_ready,
    output logic       o_rf_rd_en,
    output logic [4:0] o_cnt,
    output logic       o_cnt_en,
    output logic       o_cnt0,
    output logic       o_cnt0to3,
    output logic       o_cnt12to31,
    output logic       o_cnt_done,
    output logic [1:0] o_mem_bytecnt,
    output logic       o_init,
    output logic       o_ctrl_pc_en,
    output logic       o_ctrl_jump,
    output logic       o_ctrl_trap
);

    localparam bit RESET_EN = (RESET_STRATEGY != "NONE");
    localparam bit CSR_EN   = (WITH_CSR != 0);
    localparam bit ALIGN_EN = (ALIGN != 0);

    if (!w_legal(W)) begin : g_bad_w
        $fatal(1, "serv_seqctl: W must be 1, 2, 4 or 8");
    end

    state_t state;
    logic   ibus_cyc;
    logic   jump;
    logic   trap_r;
    logic   wait2_seen;
    logic   running;
    logic   cnt_done;
    logic   take_branch;
    logic   trap_next;

    // A pass being aborted by reset must not emit completion strobes.
    assign running = ((state == INIT) || (state == RUN)) && !(i_rst && RESET_EN);

    serv_seqctl_cnt #(
        .W        (W),
        .RESET_EN (RESET_EN)
    ) u_cnt (
        .clk      (i_clk),
        .rst      (i_rst),
        .run      (running),
        .stall    (i_stall),
        .cnt      (o_cnt),
        .cnt_en   (o_cnt_en),
        .cnt_done (cnt_done)
    );

    assign take_branch = i_branch_op & (~i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));
    assign trap_next   = CSR_EN & ((take_branch & i_ctrl_misalign & ~ALIGN_EN) |
                                   (i_dbus_en & i_mem_misalign));

    // Later assignments win: a done in RUN re-arms the fetch even when the
    // previous fetch is acknowledged in the same cycle; reset overrides all.
    always_ff @(posedge i_clk) begin
        wait2_seen <= (state == WAIT2);
        if (i_ibus_ack) begin
            ibus_cyc <= 1'b0;
        end
        case (state)
            IDLE: begin
                if (i_rf_ready) begin
                    state <= (i_two_stage_op && !i_new_irq) ? INIT : RUN;
                end
            end
            INIT: begin
                if (cnt_done) begin
                    state  <= WAIT2;
                    jump   <= take_branch;
                    trap_r <= trap_next;
                end
            end
            WAIT2: begin
                if (i_rf_ready) begin
                    state <= RUN;
                end
            end
            RUN: begin
                if (cnt_done) begin
                    state    <= IDLE;
                    ibus_cyc <= 1'b1;
                    jump     <= 1'b0;
                    trap_r   <= 1'b0;
                end
            end
            default: state <= IDLE;
        endcase
        if (i_rst) begin
            ibus_cyc <= 1'b1;
            if (RESET_EN) begin
                state      <= IDLE;
                jump       <= 1'b0;
                trap_r     <= 1'b0;
                wait2_seen <= 1'b0;
            end
        end
    end

    assign o_ibus_cyc    = ibus_cyc & ~i_rst;
    assign o_cnt_done    = cnt_done;
    assign o_cnt0        = o_cnt_en & (o_cnt == 5'd0);
    assign o_cnt0to3     = (o_cnt < 5'd4);
    assign o_cnt12to31   = (o_cnt >= 5'd12);
    assign o_mem_bytecnt = o_cnt[4:3];
    assign o_init        = (state == INIT);
    assign o_ctrl_pc_en  = o_cnt_en & (state == RUN);
    assign o_ctrl_jump   = jump;
    assign o_ctrl_trap   = CSR_EN & (i_e_op | i_new_irq | trap_r);
    assign o_rf_rd_en    = i_rd_op & (state == RUN);

    // Trapping skips the memory access and write-back; instead the RF is asked
    // once for the trap-vector read.
    assign o_dbus_cyc = (state == WAIT2) & i_dbus_en & ~i_mem_misalign & ~trap_r;
    assign o_rf_wreq  = (state == WAIT2) & ~trap_r &
                        ((i_shift_op & (i_sh_done | ~i_sh_right)) | i_dbus_ack | i_slt_or_branch);
    assign o_rf_rreq  = i_ibus_ack | ((state == WAIT2) & trap_r & ~wait2_seen);

endmodule

// File: tb/tb_serv_seqctl.sv
module tb_serv_seqctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // One DUT per width: index k drives W = 1 << k.
    logic [3:0] rst = '0, stall = '0, new_irq = '0, alu_cmp = '0, two_stage = '0;
    logic [3:0] branch_op = '0, cond_branch = '0, bne_or_bge = '0, shift_op = '0;
    logic [3:0] sh_right = '0, slt_or_branch = '0, dbus_en = '0, e_op = '0, rd_op = '0;
    logic [3:0] sh_done = '0, ctrl_misalign = '0, mem_misalign = '0;
    logic [3:0] ibus_ack = '0, dbus_ack = '0, rf_ready = '0;

    logic [3:0] ibus_cyc, dbus_cyc, rf_rreq, rf_wreq, rf_rd_en, cnt_en, cnt0, cnt0to3;
    logic [3:0] cnt12to31, cnt_done, init, pc_en, jump, trap;
    logic [4:0] cnt [4];
    logic [1:0] bytecnt [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serv_seqctl #(.W(1 << g)) dut (
            .i_clk(clk), .i_rst(rst[g]), .i_stall(stall[g]), .i_new_irq(new_irq[g]),
            .i_alu_cmp(alu_cmp[g]), .i_two_stage_op(two_stage[g]), .i_branch_op(branch_op[g]),
            .i_cond_branch(cond_branch[g]), .i_bne_or_bge(bne_or_bge[g]),
            .i_shift_op(shift_op[g]), .i_sh_right(sh_right[g]),
            .i_slt_or_branch(slt_or_branch[g]), .i_dbus_en(dbus_en[g]), .i_e_op(e_op[g]),
            .i_rd_op(rd_op[g]), .i_sh_done(sh_done[g]), .i_ctrl_misalign(ctrl_misalign[g]),
            .i_mem_misalign(mem_misalign[g]), .o_ibus_cyc(ibus_cyc[g]), .i_ibus_ack(ibus_ack[g]),
            .o_dbus_cyc(dbus_cyc[g]), .i_dbus_ack(dbus_ack[g]), .o_rf_rreq(rf_rreq[g]),
            .o_rf_wreq(rf_wreq[g]), .i_rf_ready(rf_ready[g]), .o_rf_rd_en(rf_rd_en[g]),
            .o_cnt(cnt[g]), .o_cnt_en(cnt_en[g]), .o_cnt0(cnt0[g]), .o_cnt0to3(cnt0to3[g]),
            .o_cnt12to31(cnt12to31[g]), .o_cnt_done(cnt_done[g]), .o_mem_bytecnt(bytecnt[g]),
            .o_init(init[g]), .o_ctrl_pc_en(pc_en[g]), .o_ctrl_jump(jump[g]),
            .o_ctrl_trap(trap[g])
        );
    end

    typedef struct packed {
        logic       stall;
        logic [4:0] cnt;
        logic       en;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs(input int k);
        stall[k] = 0; new_irq[k] = 0; alu_cmp[k] = 0; two_stage[k] = 0; branch_op[k] = 0;
        cond_branch[k] = 0; bne_or_bge[k] = 0; shift_op[k] = 0; sh_right[k] = 0;
        slt_or_branch[k] = 0; dbus_en[k] = 0; e_op[k] = 0; rd_op[k] = 0; sh_done[k] = 0;
        ctrl_misalign[k] = 0; mem_misalign[k] = 0; ibus_ack[k] = 0; dbus_ack[k] = 0;
        rf_ready[k] = 0;
    endtask

    task automatic do_reset(input int k);
        clear_inputs(k);
        rst[k] = 1'b1;
        cyc();
        cyc();
        rst[k] = 1'b0;
        #1;
    endtask

    // Push one full pass of expected (cnt, done) pairs for width w.
    task automatic push_pass(input int w);
        for (int i = 0; i < 32; i += w) begin
            exp_q.push_back('{stall: 1'b0, cnt: 5'(i), en: 1'b1, done: (i == 32 - w)});
        end
    endtask

    task automatic test_reset();
        rst = 4'hF;
        cyc();
        cyc();
        for (int k = 0; k < 4; k++) begin
            checks++; if (cnt[k] !== 5'd0) $display("FAIL rst_cnt k=%0d: got %0d want 0", k, cnt[k]); else passed++;
            checks++; if ({cnt_en[k], init[k], jump[k], trap[k], ibus_cyc[k], rf_rreq[k]} !== 6'b0)
                $display("FAIL rst_ctrl k=%0d: got %b want 000000", k,
                         {cnt_en[k], init[k], jump[k], trap[k], ibus_cyc[k], rf_rreq[k]});
            else passed++;
        end
        rst = 4'h0;
        #1;
        checks++; if (ibus_cyc !== 4'hF) $display("FAIL rst_fetch: got %b want 1111", ibus_cyc); else passed++;
        checks++; if ({dbus_cyc, rf_wreq} !== 8'h00) $display("FAIL rst_bus: got %h want 00", {dbus_cyc, rf_wreq}); else passed++;
    endtask

    task automatic test_add_w1();
        int k; int n; int guard; exp_t e;
        k = 0; n = 0; guard = 0;
        do_reset(k);
        rd_op[k] = 1'b1;
        ibus_ack[k] = 1'b1;
        #1;
        checks++; if (rf_rreq[k] !== 1'b1) $display("FAIL add_rreq: got %b want 1", rf_rreq[k]); else passed++;
        cyc();
        ibus_ack[k] = 1'b0;
        rf_ready[k] = 1'b1;
        #1;
        checks++; if (ibus_cyc[k] !== 1'b0) $display("FAIL add_ackclr: got %b want 0", ibus_cyc[k]); else passed++;
        push_pass(1);
        cyc();
        rf_ready[k] = 1'b0;
        #1;
        while (exp_q.size() > 0 && guard < 100) begin
            if (cnt_en[k]) begin
                e = exp_q.pop_front();
                n++;
                checks++; if (cnt[k] !== e.cnt) $display("FAIL add_cnt: got %0d want %0d", cnt[k], e.cnt); else passed++;
                checks++; if (cnt_done[k] !== e.done) $display("FAIL add_done@%0d: got %b want %b", e.cnt, cnt_done[k], e.done); else passed++;
                checks++; if ({pc_en[k], rf_rd_en[k]} !== 2'b11) $display("FAIL add_pcen: got %b want 11", {pc_en[k], rf_rd_en[k]}); else passed++;
            end
            cyc();
            guard++;
        end
        checks++; if (n !== 32) $display("FAIL add_len: got %0d want 32", n); else passed++;
        checks++; if ({cnt_en[k], ibus_cyc[k]} !== 2'b01) $display("FAIL add_refetch: got %b want 01", {cnt_en[k], ibus_cyc[k]}); else passed++;
        exp_q.delete();
    endtask

    task automatic test_branch_w4();
        int k; int n; int guard; exp_t e;
        k = 2; n = 0; guard = 0;
        do_reset(k);
        two_stage[k] = 1; branch_op[k] = 1; cond_branch[k] = 1; alu_cmp[k] = 1;
        dbus_en[k] = 1; slt_or_branch[k] = 1;
        ibus_ack[k] = 1;
        cyc();
        ibus_ack[k] = 0;
        rf_ready[k] = 1;
        push_pass(4);
        cyc();
        rf_ready[k] = 0;
        #1;
        while (init[k] && guard < 50) begin
            e = exp_q.pop_front();
            n++;
            checks++; if ({cnt[k], cnt_done[k]} !== {e.cnt, e.done})
                $display("FAIL br_init@%0d: got %0d/%b want %0d/%b", n, cnt[k], cnt_done[k], e.cnt, e.done);
            else passed++;
            cyc();
            guard++;
        end
        checks++; if (n !== 8) $display("FAIL br_init_len: got %0d want 8", n); else passed++;
        checks++; if ({jump[k], dbus_cyc[k], rf_wreq[k], rf_rreq[k], trap[k]} !== 5'b11100)
            $display("FAIL br_wait2: got %b want 11100", {jump[k], dbus_cyc[k], rf_wreq[k], rf_rreq[k], trap[k]});
        else passed++;
        rf_ready[k] = 1;
        push_pass(4);
        cyc();
        rf_ready[k] = 0;
        #1;
        n = 0; guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            if (cnt_en[k]) begin
                e = exp_q.pop_front();
                n++;
                checks++; if ({jump[k], cnt[k]} !== {1'b1, e.cnt})
                    $display("FAIL br_run@%0d: got %b/%0d want 1/%0d", n, jump[k], cnt[k], e.cnt);
                else passed++;
            end
            cyc();
            guard++;
        end
        checks++; if (n !== 8) $display("FAIL br_run_len: got %0d want 8", n); else passed++;
        checks++; if (jump[k] !== 1'b0) $display("FAIL br_jump_clr: got %b want 0", jump[k]); else passed++;
        exp_q.delete();
    endtask

    task automatic test_misalign_w2();
        int k; int n; int guard;
        k = 1; n = 0; guard = 0;
        do_reset(k);
        two_stage[k] = 1; dbus_en[k] = 1; mem_misalign[k] = 1; slt_or_branch[k] = 1; rd_op[k] = 1;
        ibus_ack[k] = 1;
        cyc();
        ibus_ack[k] = 0;
        rf_ready[k] = 1;
        cyc();
        rf_ready[k] = 0;
        #1;
        while (init[k] && guard < 50) begin
            n++;
            cyc();
            guard++;
        end
        checks++; if (n !== 16) $display("FAIL mis_init_len: got %0d want 16", n); else passed++;
        checks++; if ({rf_rreq[k], dbus_cyc[k], rf_wreq[k], trap[k]} !== 4'b1001)
            $display("FAIL mis_wait2_a: got %b want 1001", {rf_rreq[k], dbus_cyc[k], rf_wreq[k], trap[k]});
        else passed++;
        cyc();
        checks++; if ({rf_rreq[k], dbus_cyc[k], rf_wreq[k]} !== 3'b000)
            $display("FAIL mis_wait2_b: got %b want 000", {rf_rreq[k], dbus_cyc[k], rf_wreq[k]});
        else passed++;
        rf_ready[k] = 1;
        cyc();
        rf_ready[k] = 0;
        #1;
        n = 0; guard = 0;
        while (cnt_en[k] && guard < 50) begin
            n++;
            checks++; if ({trap[k], rf_rd_en[k]} !== 2'b11) $display("FAIL mis_run@%0d: got %b want 11", n, {trap[k], rf_rd_en[k]}); else passed++;
            cyc();
            guard++;
        end
        checks++; if (n !== 16) $display("FAIL mis_run_len: got %0d want 16", n); else passed++;
        checks++; if (trap[k] !== 1'b0) $display("FAIL mis_trap_clr: got %b want 0", trap[k]); else passed++;
    endtask

    task automatic test_stall_w8();
        int k; exp_t e; logic [4:0] c;
        k = 3;
        do_reset(k);
        exp_q.push_back('{stall: 1'b0, cnt: 5'd0,  en: 1'b1, done: 1'b0});
        exp_q.push_back('{stall: 1'b0, cnt: 5'd8,  en: 1'b1, done: 1'b0});
        for (int i = 0; i < 3; i++) exp_q.push_back('{stall: 1'b1, cnt: 5'd16, en: 1'b0, done: 1'b0});
        exp_q.push_back('{stall: 1'b0, cnt: 5'd16, en: 1'b1, done: 1'b0});
        exp_q.push_back('{stall: 1'b0, cnt: 5'd24, en: 1'b1, done: 1'b1});
        rf_ready[k] = 1;
        cyc();
        rf_ready[k] = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            c = e.cnt;
            stall[k] = e.stall;
            #1;
            checks++; if ({cnt[k], cnt_en[k], cnt_done[k], bytecnt[k]} !== {e.cnt, e.en, e.done, c[4:3]})
                $display("FAIL stall_cnt: got %0d/%b/%b/%0d want %0d/%b/%b/%0d", cnt[k], cnt_en[k],
                         cnt_done[k], bytecnt[k], e.cnt, e.en, e.done, c[4:3]);
            else passed++;
            checks++; if ({cnt0[k], cnt0to3[k], cnt12to31[k]} !== {e.en & (c == 0), c < 4, c >= 12})
                $display("FAIL stall_dec@%0d: got %b want %b", c, {cnt0[k], cnt0to3[k], cnt12to31[k]},
                         {e.en & (c == 0), c < 4, c >= 12});
            else passed++;
            cyc();
        end
        stall[k] = 0;
        #1;
        checks++; if ({cnt_en[k], ibus_cyc[k]} !== 2'b01) $display("FAIL stall_end: got %b want 01", {cnt_en[k], ibus_cyc[k]}); else passed++;
    endtask

    task automatic test_reset_mid();
        int k; int guard;
        k = 2; guard = 0;
        do_reset(k);
        rf_ready[k] = 1;
        cyc();
        rf_ready[k] = 0;
        while (cnt[k] !== 5'd12 && guard < 20) begin
            cyc();
            guard++;
        end
        checks++; if ({pc_en[k], cnt[k]} !== {1'b1, 5'd12}) $display("FAIL rstmid_reach: got %b/%0d want 1/12", pc_en[k], cnt[k]); else passed++;
        rst[k] = 1;
        #1;
        checks++; if (cnt_done[k] !== 1'b0) $display("FAIL rstmid_nodone: got %b want 0", cnt_done[k]); else passed++;
        cyc();
        checks++; if ({cnt[k], cnt_en[k], init[k], pc_en[k], ibus_cyc[k]} !== 9'b0)
            $display("FAIL rstmid_idle: got %0d/%b/%b/%b/%b want 0/0/0/0/0", cnt[k], cnt_en[k], init[k], pc_en[k], ibus_cyc[k]);
        else passed++;
        rst[k] = 0;
        #1;
        checks++; if (ibus_cyc[k] !== 1'b1) $display("FAIL rstmid_fetch: got %b want 1", ibus_cyc[k]); else passed++;
        cyc();
        checks++; if (cnt_en[k] !== 1'b0) $display("FAIL rstmid_stays: got %b want 0", cnt_en[k]); else passed++;
    endtask

    task automatic test_irq_w1();
        int k; int n; int guard; int trap_n; logic saw_init;
        k = 0; n = 0; guard = 0; trap_n = 0; saw_init = 0;
        do_reset(k);
        two_stage[k] = 1; new_irq[k] = 1;
        rf_ready[k] = 1;
        cyc();
        rf_ready[k] = 0;
        #1;
        while (cnt_en[k] && guard < 100) begin
            n++;
            if (init[k]) saw_init = 1'b1;
            if (trap[k] && pc_en[k]) trap_n++;
            cyc();
            guard++;
        end
        checks++; if (n !== 32) $display("FAIL irq_len: got %0d want 32", n); else passed++;
        checks++; if (saw_init !== 1'b0) $display("FAIL irq_noinit: got %b want 0", saw_init); else passed++;
        checks++; if (trap_n !== 32) $display("FAIL irq_trap: got %0d want 32", trap_n); else passed++;
        new_irq[k] = 0;
        #1;
        checks++; if (trap[k] !== 1'b0) $display("FAIL irq_trap_clr: got %b want 0", trap[k]); else passed++;
    endtask

    task automatic test_back_to_back();
        int k; int guard; exp_t e;
        k = 3; guard = 0;
        do_reset(k);
        // rf_ready stays high while running and must be ignored.
        rf_ready[k] = 1;
        push_pass(8);
        cyc();
        while (exp_q.size() > 0 && guard < 20) begin
            e = exp_q.pop_front();
            if (e.done) begin
                ibus_ack[k] = 1;
                rf_ready[k] = 0;
            end
            #1;
            checks++; if ({cnt[k], cnt_done[k]} !== {e.cnt, e.done})
                $display("FAIL b2b_cnt: got %0d/%b want %0d/%b", cnt[k], cnt_done[k], e.cnt, e.done);
            else passed++;
            if (e.done) begin
                checks++; if (rf_rreq[k] !== 1'b1) $display("FAIL b2b_rreq: got %b want 1", rf_rreq[k]); else passed++;
            end
            cyc();
            guard++;
        end
        ibus_ack[k] = 0;
        #1;
        checks++; if ({ibus_cyc[k], cnt_en[k]} !== 2'b10) $display("FAIL b2b_fetch: got %b want 10", {ibus_cyc[k], cnt_en[k]}); else passed++;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_add_w1();
        test_branch_w4();
        test_misalign_w2();
        test_stall_w8();
        test_reset_mid();
        test_irq_w1();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
